// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//   Serial receiver for 11-bit parity-protected frames on a single-wire link.
//   The frame is sent LSB first: start(0), d[0..7], parity, stop(1).
//   The block recovers the byte and re-checks its parity (even or odd).
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous reset, active high
//   rx         asynchronous serial input; the line idles high
//   data_out   last received byte
//   valid      one-cycle pulse when a frame completes
//   parity_err parity mismatch on the last frame (held until the next valid)
//   frame_err  stop bit sampled low on the last frame (held until the next valid)
//   err_count  number of errored frames; saturates at 8'hFF
//   busy       high while the receiver is not idle
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       errc_q, errc_d;

    always_comb begin
        state_d    = state_q;
        sync1_d    = rx;
        rx_s_d     = sync1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        errc_d     = errc_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Re-check the line at mid start bit so short glitches are rejected.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_PARITY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leaving at mid-stop lets a back-to-back start bit be caught in IDLE.
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    data_out_d = shift_q;
                    perr_d     = par_q != (^shift_q ^ PARITY_ODD);
                    ferr_d     = !rx_s_q;
                    valid_d    = 1'b1;
                    if ((perr_d || ferr_d) && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            errc_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rx_s_q     <= rx_s_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            errc_q     <= errc_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign err_count  = errc_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx
//   Directed plus randomized frames into parity_frame_rx (CLKS_PER_BIT=4,
//   even parity). A monitor queues every valid pulse; each received frame is
//   compared against a frame-level model of the expected byte, flags and
//   saturating error count.
module tb_parity_frame_rx;

    localparam int CPB  = 4;
    localparam bit PODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int model_ec = 0;

    logic [7:0] mq_data[$];
    logic       mq_pe[$];
    logic       mq_fe[$];
    logic [7:0] mq_ec[$];

    logic [7:0] bb_d[$];

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            mq_data.push_back(data_out);
            mq_pe.push_back(parity_err);
            mq_fe.push_back(frame_err);
            mq_ec.push_back(err_count);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    // Model: the parity bit should equal the odd-ones indicator of the byte
    // (inverted for odd parity); any errored frame bumps a count capped at 255.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
        logic ones_odd, exp_pe, exp_fe;
        bit   got;
        ones_odd = ($countones(d) % 2) == 1;
        exp_pe   = (p != (ones_odd ^ PODD));
        exp_fe   = !s;
        if ((exp_pe || exp_fe) && model_ec < 255) model_ec++;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (mq_data.size() != 0) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_data"}, 32'(mq_data.pop_front()), 32'(d));
            chk({tag, "_perr"}, 32'(mq_pe.pop_front()), 32'(exp_pe));
            chk({tag, "_ferr"}, 32'(mq_fe.pop_front()), 32'(exp_fe));
            chk({tag, "_ecnt"}, 32'(mq_ec.pop_front()), 32'(model_ec));
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data"}, 32'(data_out), 32'h00);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_perr"}, 32'(parity_err), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_ecnt"}, 32'(err_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame, even parity bit 1 for 8'hBA.
        send_frame(8'hBA, 1'b1, 1'b1); rx = 1'b1;
        expect_frame("t1_ba", 8'hBA, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Bad parity, then a good frame that clears the flag.
        send_frame(8'hBA, 1'b0, 1'b1); rx = 1'b1;
        expect_frame("t2_ba_bad", 8'hBA, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h00, 1'b0, 1'b1); rx = 1'b1;
        expect_frame("t2_00", 8'h00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Stop bit low, then a good frame clears frame_err.
        send_frame(8'h5A, 1'b0, 1'b0); rx = 1'b1;
        expect_frame("t3_5a_fe", 8'h5A, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk("t3_busy_after_fe", 32'(busy), 32'd0);
        chk("t3_no_extra_valid", 32'(mq_data.size()), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1); rx = 1'b1;
        expect_frame("t3_3c", 8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // One-cycle glitch must not produce a frame.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("t4_no_valid", 32'(mq_data.size()), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ecnt", 32'(err_count), 32'(model_ec));

        // Reset in the middle of data bit 4 aborts the frame.
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (2) @(negedge clk);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_cleared("t5_rst");
        rst = 1'b0;
        rx  = 1'b1;
        model_ec = 0;
        repeat (CPB * 12) @(negedge clk);
        chk("t5_no_valid", 32'(mq_data.size()), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b1); rx = 1'b1;
        expect_frame("t5_a5", 8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Random frames with occasional parity and stop errors.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'(($countones(d) % 2) == 1) ^ PODD;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s); rx = 1'b1;
            expect_frame("rand", d, p, s);
            repeat (s ? 3 : 12) @(negedge clk);
        end

        // 300 back-to-back bad-parity frames: count saturates at 8'hFF.
        for (int n = 0; n < 300; n++) begin
            d = 8'($urandom_range(0, 255));
            bb_d.push_back(d);
            send_frame(d, ~(1'(($countones(d) % 2) == 1) ^ PODD), 1'b1);
        end
        rx = 1'b1;
        for (int n = 0; n < 300; n++) begin
            d = bb_d.pop_front();
            expect_frame("b2b", d, ~(1'(($countones(d) % 2) == 1) ^ PODD), 1'b1);
        end
        repeat (10) @(negedge clk);
        chk("t6_ecnt_sat", 32'(err_count), 32'hFF);
        chk("t6_no_extra", 32'(mq_data.size()), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver and checker for 8-bit parity-protected frames.
- Companion to the team's XOR-reduction parity generator: the generator emits parity = ^data (even parity), and this block recovers the byte and re-checks that parity.
- Sits at the receive end of a single-wire link.
- Frame format, LSB first: start(0), 8 data bits, parity bit, stop(1).

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be an even number ≥ 4.
- PARITY_ODD, 0, 0 = even parity (parity bit == ^data); 1 = odd parity (parity bit == ~^data).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last received byte.
- valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on last frame.
- frame_err  output  1  stop bit sampled low on last frame.
- err_count  output  8  count of errored frames, saturating.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - Both rx synchronizer flops = 1.
  - FSM = IDLE; bit counter and sample counter = 0.
  - data_out = 8'h00; valid, parity_err, frame_err, busy = 0; err_count = 0.
  - Reset asserted mid-frame aborts the frame: no valid pulse, no counter update.
- Input path:
  - rx passes through a 2-flop synchronizer; all FSM decisions use the synchronized rx_s.
  - This adds 2 cycles of latency.
- FSM states:
  - IDLE: wait for rx_s == 0, then go to START with sample counter cleared.
  - START: count CLKS_PER_BIT/2 − 1 cycles, then sample at mid-bit.
    - rx_s == 0 → go to DATA, sample counter cleared.
    - rx_s == 1 → false start; return to IDLE. No flags, no count.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[idx], LSB first, idx 0..7. After idx 7 go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit, then in the same cycle:
    - data_out ← shift register.
    - parity_err ← (sampled parity != (^shift register ^ PARITY_ODD)).
    - frame_err ← (stop sample == 0).
    - valid = 1 for exactly the following cycle.
    - Return to IDLE.
- Flag hold: parity_err and frame_err keep their values until the next valid. Both may be 1 together.
- err_count:
  - Increments by 1 on a valid pulse when parity_err or frame_err is set; a frame with both errors counts once.
  - Saturates at 8'hFF and does not wrap.
- Frame-error return: after a frame_err, the FSM returns to IDLE. If rx_s is still low, it immediately treats that as a new start, and a mid-bit check then follows.
- busy = (state != IDLE); combinational from the state register.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 10×CLKS_PER_BIT (+1 registered) cycles after the rx falling edge, ±1 cycle of edge-detection jitter.
- Back-to-back frames: a start bit immediately following a stop bit must be received with no idle gap; the FSM reaches IDLE at mid-stop.
- Glitches: rx low for fewer than CLKS_PER_BIT/2 cycles must not produce valid.

Test Plan (CLKS_PER_BIT=4, PARITY_ODD=0):
1. Send data 8'b10111010 with parity 1, stop 1 → one valid pulse; data_out=8'hBA, parity_err=0, frame_err=0, err_count=0.
2. Send 8'hBA with parity 0 → valid; data_out=8'hBA, parity_err=1, err_count=1. Then send 8'h00 with parity 0 → parity_err=0, err_count stays 1.
3. Send 8'h5A with parity 0 and stop 0 → valid, frame_err=1, parity_err=0, err_count increments by 1. Then rx returns high; a following good frame 8'h3C/parity 0 clears frame_err.
4. Pulse rx low for 1 cycle only → no valid within 60 cycles; busy returns to 0; err_count unchanged.
5. Assert rst during DATA bit 4 of a frame → next cycle busy=0, valid=0, all outputs 0. A clean frame 8'hA5/parity 0 afterwards is received correctly.
6. Send 300 consecutive back-to-back frames, each with a bad parity bit → 300 valid pulses; err_count reaches 8'hFF and holds.
